// File: rtl/down_count_timer_pkg.sv
// Shared state encoding and default width for the down-count timer.
// No logic; imported by the top and referenced for parameter defaults.
package down_count_timer_pkg;

    localparam int DCT_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } dct_state_t;

endpackage

// File: rtl/down_count_stage.sv
// One bit of a borrow-chain decrementer: d minus borrow-in.
// Latency: combinational. Backpressure: none.
module down_count_stage (
    input  logic d,
    input  logic bin,
    output logic q,
    output logic bout
);

    assign q    = d ^ bin;
    assign bout = bin & ~d;

endmodule

// File: rtl/down_count_timer.sv
// Loadable down-count timer (IDLE/RUN/DONE); DOWN_COUNT_TIMER_AUTO_RELOAD_EN restarts from reload after DONE.
// Latency: start at edge k with count N -> busy k+1..k+N, done k+N+1. Backpressure: none; stop aborts a run.
module down_count_timer
    import down_count_timer_pkg::*;
#(
    parameter int WIDTH = DCT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    dct_state_t       state, state_nxt;
    logic [WIDTH-1:0] q_r, q_nxt;
    logic [WIDTH-1:0] reload_r, reload_nxt;
    logic             busy_r, done_r;
    logic [WIDTH-1:0] q_dec;
    logic [WIDTH:0]   borrow;
    logic             q_zero;
    logic [WIDTH-1:0] eff_count;

    // Borrow-in of 1 at the LSB yields q_r - 1; a borrow out of the MSB means q_r was 0.
    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_dec
        down_count_stage u_stage (
            .d    (q_r[i]),
            .bin  (borrow[i]),
            .q    (q_dec[i]),
            .bout (borrow[i+1])
        );
    end

    assign q_zero    = borrow[WIDTH];
    assign eff_count = load ? load_value : q_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            q_r      <= '0;
            reload_r <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state    <= state_nxt;
            q_r      <= q_nxt;
            reload_r <= reload_nxt;
            busy_r   <= (state_nxt == ST_RUN);
            done_r   <= (state_nxt == ST_DONE);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (eff_count != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (q_zero || (q_dec == '0)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
`ifdef DOWN_COUNT_TIMER_AUTO_RELOAD_EN
                if (!stop && (reload_r != '0)) begin
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
`else
                state_nxt = ST_IDLE;
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        q_nxt      = q_r;
        reload_nxt = reload_r;
        unique case (state)
            ST_IDLE: begin
                if (load) begin
                    q_nxt      = load_value;
                    reload_nxt = load_value;
                end
            end
            ST_RUN: begin
                // stop wins over decrement; never decrement past zero
                if (!stop && !q_zero) begin
                    q_nxt = q_dec;
                end
            end
            ST_DONE: begin
`ifdef DOWN_COUNT_TIMER_AUTO_RELOAD_EN
                if (!stop && (reload_r != '0)) begin
                    q_nxt = reload_r;
                end else begin
                    q_nxt = '0;
                end
`else
                q_nxt = '0;
`endif
            end
            default: q_nxt = '0;
        endcase
    end

    assign q    = q_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_down_count_timer.sv
// Directed bench for down_count_timer with a cycle-arithmetic reference model.
// The model predicts q as (run length - cycles elapsed since the run began).
module tb_down_count_timer;

    localparam int W = 4;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic [W-1:0] load_value;
    logic         start;
    logic         stop;
    logic [W-1:0] q;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    down_count_timer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .stop       (stop),
        .q          (q),
        .busy       (busy),
        .done       (done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: mode, the run's length and the edge index at which it began.
    int m_mode   = M_IDLE;
    int m_q      = 0;
    int m_reload = 0;
    int m_n      = 0;
    int m_t0     = 0;
    int cyc      = 0;

    always @(posedge clk or negedge reset) begin
        int eff;
        int e;
        if (!reset) begin
            m_mode   <= M_IDLE;
            m_q      <= 0;
            m_reload <= 0;
            m_n      <= 0;
            m_t0     <= 0;
            cyc      <= 0;
        end else begin
            cyc <= cyc + 1;
            case (m_mode)
                M_IDLE: begin
                    if (load) begin
                        m_q      <= int'(load_value);
                        m_reload <= int'(load_value);
                    end
                    if (start) begin
                        eff = load ? int'(load_value) : m_q;
                        if (eff > 0) begin
                            m_mode <= M_RUN;
                            m_n    <= eff;
                            m_t0   <= cyc + 1;
                        end else begin
                            m_mode <= M_DONE;
                        end
                    end
                end
                M_RUN: begin
                    e = cyc - m_t0;
                    if (stop) begin
                        m_mode <= M_IDLE;
                        m_q    <= m_n - e;
                    end else if (m_n - e == 1) begin
                        m_mode <= M_DONE;
                        m_q    <= 0;
                    end
                end
                default: begin
`ifdef DOWN_COUNT_TIMER_AUTO_RELOAD_EN
                    if (!stop && m_reload != 0) begin
                        m_mode <= M_RUN;
                        m_n    <= m_reload;
                        m_t0   <= cyc + 1;
                    end else begin
                        m_mode <= M_IDLE;
                        m_q    <= 0;
                    end
`else
                    m_mode <= M_IDLE;
                    m_q    <= 0;
`endif
                end
            endcase
        end
    end

    function automatic int exp_q();
        if (m_mode == M_RUN)  return m_n - (cyc - m_t0);
        if (m_mode == M_DONE) return 0;
        return m_q;
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            chk("model_q",    int'(q),    exp_q());
            chk("model_busy", int'(busy), int'(m_mode == M_RUN));
            chk("model_done", int'(done), int'(m_mode == M_DONE));
        end
    end

    task automatic step(input logic l, input int lv, input logic s, input logic sp);
        load       = l;
        load_value = lv[W-1:0];
        start      = s;
        stop       = sp;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic lit(input string nm, input int eq, input int eb, input int ed);
        chk({nm, "_q"},    int'(q),    eq);
        chk({nm, "_busy"}, int'(busy), eb);
        chk({nm, "_done"}, int'(done), ed);
    endtask

    initial begin
        reset      = 1'b0;
        load       = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        load_value = '0;
        #1;
        lit("reset_state", 0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        step(0, 0, 0, 0);
        lit("post_reset_idle", 0, 0, 0);

        // load 5, start next cycle
        step(1, 5, 0, 0);
        lit("load5", 5, 0, 0);
        step(0, 0, 1, 0);
        lit("run5_c1", 5, 1, 0);
        for (int i = 4; i >= 1; i--) begin
            step(0, 0, 0, 0);
            lit("run5_dec", i, 1, 0);
        end
        step(0, 0, 0, 0);
        lit("run5_done", 0, 0, 1);
        step(0, 0, 0, 1);
        lit("run5_after", 0, 0, 0);

        // load and start together with 3
        step(1, 3, 1, 0);
        lit("ls3_c1", 3, 1, 0);
        step(0, 0, 0, 0);
        lit("ls3_c2", 2, 1, 0);
        step(0, 0, 0, 0);
        lit("ls3_c3", 1, 1, 0);
        step(0, 0, 0, 0);
        lit("ls3_done", 0, 0, 1);
        step(0, 0, 0, 1);
        lit("ls3_after", 0, 0, 0);

        // zero-length run
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        lit("zero_done", 0, 0, 1);
        step(0, 0, 0, 0);
        lit("zero_after", 0, 0, 0);

        // stop at 6, resume, ignored start/load in RUN, stop again
        step(1, 9, 0, 0);
        step(0, 0, 1, 0);
        lit("stop_c1", 9, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        lit("stop_at6", 6, 1, 0);
        step(0, 0, 0, 1);
        lit("stopped", 6, 0, 0);
        step(0, 0, 0, 1);
        lit("stop_in_idle", 6, 0, 0);
        step(0, 0, 1, 0);
        lit("resume", 6, 1, 0);
        step(0, 0, 1, 0);
        lit("start_in_run", 5, 1, 0);
        step(1, 2, 0, 0);
        lit("load_in_run", 4, 1, 0);
        step(0, 0, 0, 1);
        lit("stop2", 4, 0, 0);
        step(0, 0, 0, 0);
        lit("stop2_hold", 4, 0, 0);

        // asynchronous reset mid-run at q=10
        step(1, 15, 0, 0);
        step(0, 0, 1, 0);
        lit("arst_c1", 15, 1, 0);
        repeat (5) step(0, 0, 0, 0);
        lit("arst_at10", 10, 1, 0);
        #2 reset = 1'b0;
        #1;
        lit("arst_immediate", 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        step(0, 0, 0, 0);
        lit("arst_after", 0, 0, 0);
        step(0, 0, 0, 0);
        lit("arst_no_done", 0, 0, 0);

        // load 2, start: auto-reload repeats, otherwise a single pulse
        step(1, 2, 0, 0);
        step(0, 0, 1, 0);
        lit("ar_c1", 2, 1, 0);
        step(0, 0, 0, 0);
        lit("ar_c2", 1, 1, 0);
        step(0, 0, 0, 0);
        lit("ar_done1", 0, 0, 1);
`ifdef DOWN_COUNT_TIMER_AUTO_RELOAD_EN
        step(0, 0, 0, 0);
        lit("ar_c4", 2, 1, 0);
        step(0, 0, 0, 0);
        lit("ar_c5", 1, 1, 0);
        step(0, 0, 0, 0);
        lit("ar_done2", 0, 0, 1);
        step(0, 0, 0, 1);
        lit("ar_stop", 0, 0, 0);
        step(0, 0, 0, 0);
        lit("ar_idle", 0, 0, 0);
`else
        step(0, 0, 0, 0);
        lit("ar_single", 0, 0, 0);
        step(0, 0, 0, 0);
        lit("ar_idle", 0, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
